// File: rtl/lsu_pkg.sv
// Shared types, funct3/fault-cause codes and access-legality helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  function automatic logic size_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    logic ill;
    if (rd && wr) ill = 1'b1;
    else if (wr)  ill = !(f3 inside {F3_B, F3_H, F3_W});
    else          ill = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return ill;
  endfunction

  // Only meaningful for legal funct3 values; byte accesses are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte enables, load lane select and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wd_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o = st_wd_i;
    st_be_o    = 4'b1111;
    if (st_we_i) begin
      case (st_f3_i)
        F3_B: begin
          st_wdata_o = {4{st_wd_i[7:0]}};
          st_be_o    = 4'b0001 << st_lo_i;
        end
        F3_H: begin
          st_wdata_o = {2{st_wd_i[15:0]}};
          st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = ld_raw_i[{ld_lo_i, 3'b000} +: 8];
    ld_half = ld_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes an ALU-addressed access, runs a req/ready memory handshake with a
// wait-state timeout, and returns an extended load result or a one-cycle fault pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemBe,
  input  logic        MemReady,
  input  logic [31:0] MemRdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: while in BUSY, MemReq stays high with address/data/enables held; the access
  // completes on the first rising edge where MemReady is high. MemReady is ignored elsewhere.

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        illegal;
  logic        misal;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign access  = MemRead | MemWrite;
  assign illegal = size_illegal(MemRead, MemWrite, Funct3);
  assign misal   = misaligned(Funct3, ALUResult[1:0]);

  lsu_align u_align (
    .st_we_i    (MemWrite),
    .st_f3_i    (Funct3),
    .st_lo_i    (ALUResult[1:0]),
    .st_wd_i    (WriteData),
    .st_wdata_o (st_wdata),
    .st_be_o    (st_be),
    .ld_f3_i    (f3_q),
    .ld_lo_i    (addr_q[1:0]),
    .ld_raw_i   (MemRdata),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      cause_q <= FC_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cause_d    = cause_q;
    rdata_d    = rdata_q;
    Stall      = 1'b0;
    MemReq     = 1'b0;
    Done       = 1'b0;
    Fault      = 1'b0;
    FaultCause = FC_NONE;
    ReadData   = '0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so a held request cannot stall the core while reset is asserted.
        Stall = access & rst_n;
        if (access) begin
          if (illegal) begin
            cause_d = FC_ILLEGAL;
            state_d = S_FAULT;
          end else if (misal) begin
            cause_d = FC_MISALIGN;
            state_d = S_FAULT;
          end else begin
            addr_d  = ALUResult;
            f3_d    = Funct3;
            we_d    = MemWrite;
            wdata_d = st_wdata;
            be_d    = st_be;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        MemReq = 1'b1;
        Stall  = 1'b1;
        if (MemReady) begin
          rdata_d = we_q ? 32'b0 : ld_data;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cause_d = FC_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        Done     = 1'b1;
        ReadData = rdata_q;
        state_d  = S_IDLE;
      end
      S_FAULT: begin
        Fault      = 1'b1;
        FaultCause = cause_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MemAddr  = {addr_q[31:2], 2'b00};
  assign MemWe    = we_q;
  assign MemWdata = wdata_q;
  assign MemBe    = be_q;

endmodule
